// File: rtl/quad_pkg.sv
// quad_pkg: quadrature phase type, Gray-sequence helpers and direction encoding
package quad_pkg;
    typedef logic [1:0] phase_t;
    typedef enum logic {IDLE, RUN} state_t;
    localparam phase_t PH_00 = 2'b00;
    localparam phase_t PH_10 = 2'b10;
    localparam phase_t PH_11 = 2'b11;
    localparam phase_t PH_01 = 2'b01;
    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;
    function automatic phase_t next_fwd(input phase_t p);
        return {~p[0], p[1]};
    endfunction
    function automatic phase_t next_rev(input phase_t p);
        return {p[0], ~p[1]};
    endfunction
endpackage

// File: rtl/quad_encoder_tx_step_timer.sv
// step_timer: reloadable down-counter that flags when the inter-edge interval has elapsed
module step_timer #(
    parameter int STEP_CYCLES = 2500,
    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);
    localparam logic [TW-1:0] RELOAD = TW'(STEP_CYCLES - 1);
    logic [TW-1:0] count_q, count_d;
    always_comb count_d = load ? RELOAD : (en && count_q != '0) ? count_q - TW'(1) : count_q;
    always_ff @(posedge clk) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end
    assign zero = (count_q == '0);
endmodule

// File: rtl/quad_encoder_tx.sv
// quad_encoder_tx: emits a Gray-coded A/B step sequence on command and tracks absolute position
module quad_encoder_tx
    import quad_pkg::*;
#(
    parameter int STEP_CYCLES = 2500,
    parameter int CNT_W       = 8,
    parameter int POS_W       = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_abort,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic [POS_W-1:0] pos
);
    state_t             state_q, state_d;
    phase_t             phase_q, phase_d;
    logic               dir_q, dir_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               accept, fire, last, t_zero, t_load, t_en;

    step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (t_load),
        .en   (t_en),
        .zero (t_zero)
    );

    // Abort outranks a due edge, so fire is suppressed whenever cmd_abort is high in RUN.
    always_comb begin
        accept  = (state_q == IDLE) && cmd_valid && (cmd_steps != '0);
        fire    = (state_q == RUN) && t_zero && !cmd_abort;
        last    = (rem_q == CNT_W'(1));
        t_load  = accept || (fire && !last);
        t_en    = (state_q == RUN);
        state_d = accept ? RUN
                : ((state_q == RUN) && (cmd_abort || (fire && last))) ? IDLE
                : state_q;
        dir_d   = accept ? cmd_dir : dir_q;
        rem_d   = accept ? cmd_steps : fire ? rem_q - CNT_W'(1) : rem_q;
        phase_d = !fire ? phase_q : (dir_q == DIR_FWD) ? next_fwd(phase_q) : next_rev(phase_q);
        pos_d   = !fire ? pos_q : (dir_q == DIR_FWD) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= PH_00;
            dir_q   <= DIR_FWD;
            rem_q   <= '0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            pos_q   <= pos_d;
        end
    end

    assign a         = phase_q[1];
    assign b         = phase_q[0];
    assign cmd_ready = (state_q == IDLE);
    assign busy      = !cmd_ready;
    assign pos       = pos_q;
endmodule

// File: tb/tb_quad_encoder_tx.sv
// tb_quad_encoder_tx: directed and random checks against an edge-schedule reference model
module tb_quad_encoder_tx;
    localparam int S = 4;
    logic clk = 0;
    always #5 clk = ~clk;

    logic       rst_n = 0, cmd_valid = 0, cmd_dir = 0, cmd_abort = 0;
    logic [7:0] cmd_steps = 0;
    logic       cmd_ready, a, b, busy;
    logic [9:0] pos;

    logic       rst1_n = 0, v1 = 0;
    logic [7:0] s1 = 0;
    logic       r1, a1, b1, busy1;
    logic [9:0] pos1;

    quad_encoder_tx #(.STEP_CYCLES(S), .CNT_W(8), .POS_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_abort(cmd_abort),
        .a(a), .b(b), .busy(busy), .pos(pos));

    quad_encoder_tx #(.STEP_CYCLES(1), .CNT_W(8), .POS_W(10)) dut1 (
        .clk(clk), .rst_n(rst1_n), .cmd_valid(v1), .cmd_ready(r1),
        .cmd_dir(1'b1), .cmd_steps(s1), .cmd_abort(1'b0),
        .a(a1), .b(b1), .busy(busy1), .pos(pos1));

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    logic [1:0] ph_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int  m_ph = 0, m_pos = 0, m_left = 0, m_next = 0;
    bit  m_busy = 0, m_dir = 0;
    logic [1:0] prev_ab = 2'b00;
    int  dec_pos = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ph_idx(input logic [1:0] p);
        for (int i = 0; i < 4; i++) if (ph_tab[i] == p) return i;
        return 0;
    endfunction

    task automatic step(input logic v, input logic d, input logic [7:0] s,
                        input logic ab, input logic rn);
        logic [1:0] cur;
        cmd_valid = v; cmd_dir = d; cmd_steps = s; cmd_abort = ab; rst_n = rn;
        @(posedge clk);
        cyc++;
        if (!rn) begin
            m_busy = 0; m_ph = 0; m_pos = 0;
        end else if (m_busy) begin
            if (ab) m_busy = 0;
            else if (cyc == m_next) begin
                m_ph  = (m_ph + (m_dir ? 1 : 3)) % 4;
                m_pos = (m_pos + (m_dir ? 1 : 1023)) % 1024;
                m_left--;
                if (m_left == 0) m_busy = 0;
                else m_next = cyc + S;
            end
        end else if (v && s != 0) begin
            m_busy = 1; m_dir = d; m_left = s; m_next = cyc + S;
        end
        #1;
        cmd_valid = 0; cmd_abort = 0;
        cur = {a, b};
        chk("ab", 32'(cur), 32'(ph_tab[m_ph]));
        chk("pos", 32'(pos), m_pos);
        chk("ready", 32'(cmd_ready), 32'(!m_busy));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("one_bit_toggle", 32'((cur[1] ^ prev_ab[1]) & (cur[0] ^ prev_ab[0])), 0);
        if (!rn) dec_pos = 0;
        else if (cur == ph_tab[(ph_idx(prev_ab) + 1) % 4]) dec_pos = (dec_pos + 1) % 1024;
        else if (cur == ph_tab[(ph_idx(prev_ab) + 3) % 4]) dec_pos = (dec_pos + 1023) % 1024;
        chk("decoder_pos", 32'(pos), dec_pos);
        prev_ab = cur;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
    endtask

    initial begin
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_ab", 32'({a, b}), 0);
        chk("rst_pos", 32'(pos), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);

        rst1_n = 1;
        idle(1);
        v1 = 1; s1 = 3;
        idle(1);
        v1 = 0;
        for (int k = 1; k <= 3; k++) begin
            idle(1);
            chk("s1_ab", 32'({a1, b1}), 32'(ph_tab[k]));
            chk("s1_ready", 32'(r1), 32'(k == 3));
        end
        chk("s1_pos", 32'(pos1), 3);

        step(1, 1, 4, 0, 1);
        for (int k = 1; k <= 16; k++) begin
            idle(1);
            if (k == 4)  chk("fwd_e1", 32'({a, b}), 32'h2);
            if (k == 8)  chk("fwd_e2", 32'({a, b}), 32'h3);
            if (k == 12) chk("fwd_e3", 32'({a, b}), 32'h1);
            if (k == 15) chk("fwd_ready15", 32'(cmd_ready), 0);
            if (k == 16) begin
                chk("fwd_e4", 32'({a, b}), 32'h0);
                chk("fwd_ready16", 32'(cmd_ready), 1);
                chk("fwd_pos", 32'(pos), 4);
            end
        end

        step(0, 0, 0, 0, 0);
        step(1, 0, 3, 0, 1);
        for (int k = 1; k <= 12; k++) begin
            idle(1);
            if (k == 4)  chk("rev_e1", 32'({a, b}), 32'h1);
            if (k == 8)  chk("rev_e2", 32'({a, b}), 32'h3);
            if (k == 12) chk("rev_e3", 32'({a, b}), 32'h2);
        end
        chk("rev_pos_wrap", 32'(pos), 32'h3FD);

        step(1, 1, 0, 0, 1);
        for (int k = 0; k < 20; k++) begin
            idle(1);
            chk("noop_ready", 32'(cmd_ready), 1);
            chk("noop_pos", 32'(pos), 32'h3FD);
        end

        step(0, 0, 0, 0, 0);
        step(1, 1, 4, 0, 1);
        idle(6);
        step(0, 0, 0, 1, 1);
        chk("abort_ready", 32'(cmd_ready), 1);
        chk("abort_ab", 32'({a, b}), 32'h2);
        chk("abort_pos", 32'(pos), 1);
        idle(1);
        chk("abort_no_edge", 32'({a, b}), 32'h2);
        idle(3);

        step(1, 1, 2, 1, 1);
        idle(3);
        step(0, 0, 0, 1, 1);
        chk("abort_wins_ab", 32'({a, b}), 32'h2);
        step(0, 0, 0, 1, 1);
        idle(2);

        step(1, 1, 255, 0, 1);
        idle(255 * S);
        chk("max_run_pos", 32'(pos), (1 + 255) % 1024);

        for (int it = 0; it < 40; it++) begin
            step(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 10)), 0, 1);
            for (int c = 0; c < int'($urandom_range(0, 60)); c++) begin
                if ($urandom_range(0, 59) == 0) step(0, 0, 0, 0, 0);
                else step($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 5)), $urandom_range(0, 39) == 0, 1);
            end
        end
        idle(50);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/quad_encoder_tx.md
Name: quad_encoder_tx

Overview:
Quadrature encoder emitter: the transmit end of the A/B rotary-encoder interface that the paddle decoders consume on ui_in. Accepts step commands over a valid/ready handshake and emits a Gray-coded A/B sequence at a programmable edge rate. Used for attract/demo mode (CPU-driven paddle) and as a bench stimulus source for the paddle decoders. Also tracks its own absolute position.

Parameters:
STEP_CYCLES, 2500, clk cycles between successive quadrature edges (min 1)
CNT_W, 8, width of the step-count field
POS_W, 10, width of the position counter (matches the paddle move width)

Ports:
clk  in  1  system clock (pixel clock domain)
rst_n  in  1  reset, synchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_dir  in  1  1 = forward (A leads B), 0 = reverse
cmd_steps  in  CNT_W  number of quadrature edges to emit
cmd_abort  in  1  stop the current run after the current cycle
a  out  1  quadrature channel A
b  out  1  quadrature channel B
busy  out  1  run in progress; equals !cmd_ready
pos  out  POS_W  signed-agnostic position, +1 per forward edge, -1 per reverse edge, modulo 2^POS_W

Behaviour:
- Reset: sampled on posedge clk when rst_n=0.
  - Outputs: a=0, b=0, pos=0, cmd_ready=1, busy=0.
  - Internal: state=IDLE, timer=0, remaining=0.
  - Applies mid-run: the run is discarded with no further edges.
- Phase {a,b}:
  - Forward: 00→10→11→01→00.
  - Reverse: 00→01→11→10→00.
  - Exactly one bit changes per edge. Both bits never toggle in the same cycle.
- Handshake:
  - cmd_ready = (state==IDLE).
  - A command is accepted when cmd_valid && cmd_ready at a posedge.
  - cmd_valid while not ready is ignored and does not queue.
- IDLE:
  - On accept with cmd_steps==0: no-op. Stay IDLE with ready=1 and no edge.
  - On accept with cmd_steps>0: latch dir; set remaining=cmd_steps; set timer=STEP_CYCLES-1; go to RUN.
- RUN:
  - While timer!=0: decrement timer each cycle.
  - When timer==0: emit an edge. This advances the phase by dir, updates pos by ±1 with wrap, and decrements remaining.
    - If remaining becomes 0: go to IDLE in the same cycle.
    - Otherwise reload timer to STEP_CYCLES-1.
- Latency: if a command is accepted at cycle 0, edge k (1-based) appears on the outputs at cycle k*STEP_CYCLES. cmd_ready is 1 in the cycle the last edge appears.
- Abort:
  - cmd_abort in RUN returns to IDLE next cycle with no edge.
  - If abort and edge-due coincide, abort wins and the edge is not emitted.
  - Phase and pos are held as they are.
  - cmd_abort in IDLE has no effect.
  - Simultaneous cmd_valid+cmd_abort in IDLE: the command is accepted and the abort is ignored.
- Phase and pos persist across commands. A new run continues from the current phase.
- Width rules:
  - timer width = max(1, clog2(STEP_CYCLES)).
  - With STEP_CYCLES=1, an edge is emitted every cycle.
  - remaining is CNT_W wide. Max run = 2^CNT_W-1 edges.
  - pos wraps 2^POS_W-1 ↔ 0.
- All outputs are registered. No combinational path from cmd_* to a/b/pos.

Decomposition:
- Shared package quad_pkg, reused by the paddle decoder side:
  - 2-bit phase type.
  - Constants PH_00/PH_10/PH_11/PH_01.
  - Functions next_fwd(phase) and next_rev(phase).
  - Dir encoding constants DIR_FWD=1, DIR_REV=0.
- One natural sub-module, step_timer, providing a down-counter with load, enable, and a zero flag, parameterised by STEP_CYCLES.
- The FSM, phase register, remaining counter and pos counter stay in quad_encoder_tx.

Test Plan:
- rst_n=0 for 2 cycles → a=0, b=0, pos=0, cmd_ready=1, busy=0.
- STEP_CYCLES=4; accept fwd, steps=4 at cycle 0 →
  - {a,b}=10@4, 11@8, 01@12, 00@16.
  - pos=4.
  - cmd_ready=0 on cycles 1–15 and 1 at cycle 16.
- From reset, rev, steps=3 → {a,b}=01, 11, 10 and pos=1021 (0x3FD), confirming wrap.
- Accept steps=0 → cmd_ready stays 1; a, b and pos are unchanged for 20 cycles.
- STEP_CYCLES=4; fwd steps=4; cmd_abort at cycle 6 → exactly one edge ({a,b}=10); pos=1; cmd_ready=1 at cycle 7; no edge at cycle 8.
- Random commands with mid-run rst_n pulses, outputs fed into a paddle decoder instance →
  - Assertion: no cycle toggles both a and b.
  - Decoder move tracks pos.
  - After each reset: a=b=0 and pos=0 on the next cycle.
